// File: rtl/object_sprite_drawer_pkg.sv
// Shared types for the sprite drawer: coordinate widths, FSM encoding and a busy decode helper.
package object_sprite_drawer_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_DRAW     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DONE     = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    case (s)
      ST_LOAD, ST_DRAW, ST_FLUSH, ST_DONE: state_is_busy = 1'b1;
      default:                             state_is_busy = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/object_sprite_drawer_scan_counter.sv
// Column/row raster counter for one sprite, with a flag marking the final pixel.
module sprite_scan_counter #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_step,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);

  localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/object_sprite_drawer.sv
// Draws one sprite into the VGA adapter per enable request, then pulses done and bumps count.
// Optional build macro TRANSPARENT_KEY_EN suppresses plotting of KEY_COLOR pixels.
module object_sprite_drawer
  import object_sprite_drawer_pkg::*;
#(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 3'b000,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H),
  localparam int AW = CW + RW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [X_W-1:0]     obj_x,
  input  logic [Y_W-1:0]     obj_y,
  input  logic               count_clr_n,
  output logic [AW-1:0]      rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

`ifdef TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  state_e           r_state, w_next_state;
  logic [X_W-1:0]   r_obj_x;
  logic [Y_W-1:0]   r_obj_y;
  logic [AW-1:0]    r_rom_addr;
  logic [X_W:0]     r_a_x;
  logic [Y_W:0]     r_a_y;
  logic             r_a_valid;
  logic [X_W-1:0]   r_vga_x;
  logic [Y_W-1:0]   r_vga_y;
  logic             r_plot;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_last;
  logic             w_issue;
  logic             w_a_on;
  logic             w_plot;

  sprite_scan_counter #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == ST_LOAD),
    .i_step  (w_issue),
    .o_col   (w_col),
    .o_row   (w_row),
    .o_last  (w_last)
  );

  assign w_issue = (r_state == ST_DRAW) && enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Dropping enable before DONE abandons the sprite; WAIT_LOW blocks re-triggering on a held request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     w_next_state = enable ? ST_LOAD : ST_IDLE;
      ST_LOAD:     w_next_state = enable ? ST_DRAW : ST_IDLE;
      ST_DRAW:     w_next_state = !enable ? ST_IDLE : (w_last ? ST_FLUSH : ST_DRAW);
      ST_FLUSH:    w_next_state = enable ? ST_DONE : ST_IDLE;
      ST_DONE:     w_next_state = ST_WAIT_LOW;
      ST_WAIT_LOW: w_next_state = enable ? ST_WAIT_LOW : ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_obj_x    <= '0;
      r_obj_y    <= '0;
      r_rom_addr <= '0;
      r_a_x      <= '0;
      r_a_y      <= '0;
      r_a_valid  <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_obj_x <= obj_x;
        r_obj_y <= obj_y;
      end
      r_a_valid <= w_issue;
      // Sums keep a carry bit so sprites hanging off the right/bottom edge clip rather than wrap.
      if (w_issue) begin
        r_rom_addr <= {w_row, w_col};
        r_a_x      <= {1'b0, r_obj_x} + (X_W+1)'(w_col);
        r_a_y      <= {1'b0, r_obj_y} + (Y_W+1)'(w_row);
      end
    end
  end

  assign w_a_on = (r_a_x < (X_W+1)'(SCR_W)) && (r_a_y < (Y_W+1)'(SCR_H));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_x <= '0;
      r_vga_y <= '0;
      r_plot  <= 1'b0;
    end else begin
      r_plot <= r_a_valid && w_a_on;
      if (r_a_valid) begin
        r_vga_x <= r_a_x[X_W-1:0];
        r_vga_y <= r_a_y[Y_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_busy <= state_is_busy(w_next_state);
      r_done <= (w_next_state == ST_DONE);
      if (!count_clr_n)
        r_count <= '0;
      else if ((r_state == ST_DONE) && (r_count != 8'hFF))
        r_count <= r_count + 8'd1;
    end
  end

  // ROM data arrives in the same cycle as the registered coordinates, so colour passes straight through.
  assign w_plot     = r_plot && !(KEY_EN && (rom_data == KEY_COLOR));
  assign vga_plot   = w_plot;
  assign vga_colour = w_plot ? rom_data : '0;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign rom_addr   = r_rom_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign count      = r_count;

endmodule

// File: tb/tb_object_sprite_drawer.sv
// Self-checking bench: scoreboard of expected plots plus per-scenario timing/count checks.
module tb_object_sprite_drawer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] obj_x = 8'd0;
  logic [6:0] obj_y = 7'd0;
  logic       count_clr_n = 1'b1;
  logic [7:0] rom_addr;
  logic [2:0] rom_data = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic [7:0] count;

  logic [2:0] rom_mem [256];
  pix_t       exp_q [$];
  pix_t       e;
  int         total = 0;
  int         bad = 0;
  int         n_plots = 0;

  object_sprite_drawer dut (
    .clk(clk), .reset(reset), .enable(enable), .obj_x(obj_x), .obj_y(obj_y),
    .count_clr_n(count_clr_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  always @(negedge clk) begin
    if (!reset && vga_plot === 1'b1) begin
      n_plots = n_plots + 1;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL plot_unexpected got (%0d,%0d,%0d) required no plot", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== {e.x, e.y, e.c}) begin
          bad = bad + 1;
          $display("FAIL plot_pixel got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  function automatic void push_exp(input logic [7:0] x, input logic [6:0] y, input int npix);
    pix_t p;
    for (int i = 0; i < npix; i++) begin
      int xx, yy;
      xx = int'(x) + (i % 16);
      yy = int'(y) + (i / 16);
      p.x = xx[7:0];
      p.y = yy[6:0];
      p.c = rom_mem[i];
`ifdef TRANSPARENT_KEY_EN
      if (xx < 160 && yy < 120 && p.c != 3'd0) exp_q.push_back(p);
`else
      if (xx < 160 && yy < 120) exp_q.push_back(p);
`endif
    end
  endfunction

  function automatic void rom_mod8();
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'(i % 8);
  endfunction

  task automatic run_draw(input logic [7:0] x, input logic [6:0] y, output int lat);
    obj_x = x;
    obj_y = y;
    push_exp(x, y, 256);
    enable = 1'b1;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 3) begin
        obj_x = ~x;
        obj_y = ~y;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total = total + 1;
    if ({rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, count} !== 37'd0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs got %h required 0",
               {rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, count});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total = total + 1;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_idle got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, p0;
    rom_mod8();
    p0 = n_plots;
    run_draw(8'd10, 7'd20, lat);
    total = total + 4;
    if (lat !== 259) begin bad = bad + 1; $display("FAIL basic_latency got %0d required 259", lat); end
    if (n_plots - p0 !== 256) begin bad = bad + 1; $display("FAIL basic_plots got %0d required 256", n_plots - p0); end
    if (count !== 8'd1) begin bad = bad + 1; $display("FAIL basic_count got %0d required 1", count); end
    if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL basic_missing got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_offscreen();
    int lat, p0;
    p0 = n_plots;
    run_draw(8'd150, 7'd110, lat);
    total = total + 3;
    if (lat !== 259) begin bad = bad + 1; $display("FAIL clip_latency got %0d required 259", lat); end
    if (n_plots - p0 !== 100) begin bad = bad + 1; $display("FAIL clip_plots got %0d required 100", n_plots - p0); end
    if (count !== 8'd2) begin bad = bad + 1; $display("FAIL clip_count got %0d required 2", count); end
  endtask

  task automatic test_held();
    int dones, lat;
    count_clr_n = 1'b0;
    @(negedge clk);
    count_clr_n = 1'b1;
    obj_x = 8'd10;
    obj_y = 7'd20;
    push_exp(8'd10, 7'd20, 256);
    enable = 1'b1;
    dones = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones = dones + 1;
    end
    total = total + 2;
    if (dones !== 1) begin bad = bad + 1; $display("FAIL held_dones got %0d required 1", dones); end
    if (count !== 8'd1) begin bad = bad + 1; $display("FAIL held_count got %0d required 1", count); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    run_draw(8'd10, 7'd20, lat);
    total = total + 2;
    if (lat !== 259) begin bad = bad + 1; $display("FAIL redraw_latency got %0d required 259", lat); end
    if (count !== 8'd2) begin bad = bad + 1; $display("FAIL redraw_count got %0d required 2", count); end
  endtask

  task automatic test_abort();
    int dones;
    logic [7:0] c0;
    c0 = count;
    obj_x = 8'd40;
    obj_y = 7'd30;
    push_exp(8'd40, 7'd30, 50);
    enable = 1'b1;
    repeat (52) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total = total + 1;
    if (busy !== 1'b0) begin bad = bad + 1; $display("FAIL abort_idle got busy=%b required 0", busy); end
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones = dones + 1;
    end
    total = total + 3;
    if (dones !== 0) begin bad = bad + 1; $display("FAIL abort_done got %0d required 0", dones); end
    if (count !== c0) begin bad = bad + 1; $display("FAIL abort_count got %0d required %0d", count, c0); end
    if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL abort_plots got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_clear_in_done();
    obj_x = 8'd0;
    obj_y = 7'd0;
    push_exp(8'd0, 7'd0, 256);
    enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    count_clr_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    count_clr_n = 1'b1;
    repeat (3) @(negedge clk);
    total = total + 1;
    if (count !== 8'd0) begin bad = bad + 1; $display("FAIL clear_in_done got %0d required 0", count); end
  endtask

  task automatic test_reset_mid();
    obj_x = 8'd5;
    obj_y = 7'd5;
    push_exp(8'd5, 7'd5, 256);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    total = total + 1;
    if ({rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, count} !== 37'd0) begin
      bad = bad + 1;
      $display("FAIL reset_mid got %h required 0",
               {rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, count});
    end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_transparent();
    int lat, p0, want;
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'd0;
    rom_mem[0] = 3'd5;
`ifdef TRANSPARENT_KEY_EN
    want = 1;
`else
    want = 256;
`endif
    p0 = n_plots;
    run_draw(8'd10, 7'd20, lat);
    total = total + 2;
    if (lat !== 259) begin bad = bad + 1; $display("FAIL key_latency got %0d required 259", lat); end
    if (n_plots - p0 !== want) begin bad = bad + 1; $display("FAIL key_plots got %0d required %0d", n_plots - p0, want); end
  endtask

  task automatic test_saturate();
    int lat, lbad;
    count_clr_n = 1'b0;
    @(negedge clk);
    count_clr_n = 1'b1;
    lbad = 0;
    for (int k = 0; k < 255; k++) begin
      run_draw(8'd250, 7'd0, lat);
      if (lat !== 259) lbad = lbad + 1;
    end
    total = total + 3;
    if (lbad !== 0) begin bad = bad + 1; $display("FAIL sat_latency got %0d slow draws required 0", lbad); end
    if (count !== 8'd255) begin bad = bad + 1; $display("FAIL sat_reach got %0d required 255", count); end
    run_draw(8'd250, 7'd0, lat);
    if (count !== 8'd255) begin bad = bad + 1; $display("FAIL sat_hold got %0d required 255", count); end
  endtask

  initial begin
    rom_mod8();
    test_reset();
    test_basic();
    test_offscreen();
    test_held();
    test_abort();
    test_clear_in_done();
    test_reset_mid();
    test_transparent();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
